// File: rtl/universal_shift_seq_if.sv
// Command/data bundle for the universal shift sequencer.
// The master issues commands and serial data; the slave owns the register.
interface universal_shift_seq_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH) + 1
);
  logic             start;
  logic [2:0]       mode;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] din;
  logic             sin;
  logic             en;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, cnt, din, sin, en,
    input  q, sout_r, sout_l, busy, done
  );

  modport slave (
    input  start, mode, cnt, din, sin, en,
    output q, sout_r, sout_l, busy, done
  );
endinterface

// File: rtl/universal_shift_seq.sv
// Parametrised universal shift register that runs counted shift/rotate
// commands (start/busy/done handshake) and single-cycle parallel loads.
module universal_shift_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  universal_shift_seq_if.slave bus
);
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SRL  = 3'b001;
  localparam logic [2:0] MODE_SLL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [2:0]       mode_reg, mode_next;
  logic [CW-1:0]    remain_reg, remain_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] step_q;
  logic             is_shift_cmd;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      q_reg      <= '0;
      mode_reg   <= MODE_HOLD;
      remain_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      q_reg      <= q_next;
      mode_reg   <= mode_next;
      remain_reg <= remain_next;
      done_reg   <= done_next;
    end
  end

  // One single-bit step of the latched command; sin is taken live.
  always_comb begin
    step_q = q_reg;
    case (mode_reg)
      MODE_SRL: step_q = {bus.sin, q_reg[WIDTH-1:1]};
      MODE_SLL: step_q = {q_reg[WIDTH-2:0], bus.sin};
      MODE_ROR: step_q = {q_reg[0], q_reg[WIDTH-1:1]};
      MODE_ROL: step_q = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
      MODE_ASR: step_q = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
      default:  step_q = q_reg;
    endcase
  end

  always_comb begin
    is_shift_cmd = (bus.mode == MODE_SRL) || (bus.mode == MODE_SLL) ||
                   (bus.mode == MODE_ROR) || (bus.mode == MODE_ROL) ||
                   (bus.mode == MODE_ASR);
  end

  always_comb begin
    state_next  = state_reg;
    q_next      = q_reg;
    mode_next   = mode_reg;
    remain_next = remain_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (bus.mode == MODE_LOAD) begin
            q_next    = bus.din;
            done_next = 1'b1;
          end else if (is_shift_cmd && (bus.cnt != '0)) begin
            mode_next   = bus.mode;
            remain_next = bus.cnt;
            state_next  = RUN;
          end else begin
            // hold, reserved or zero-length commands complete immediately
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.en) begin
          q_next      = step_q;
          remain_next = remain_reg - CW'(1);
          if (remain_reg == CW'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.q      = q_reg;
  assign bus.sout_r = q_reg[0];
  assign bus.sout_l = q_reg[WIDTH-1];
  assign bus.busy   = (state_reg == RUN);
  assign bus.done   = done_reg;
endmodule

// File: tb/tb_universal_shift_seq.sv
// Directed vector table plus randomized run against an arithmetic reference
// model of the universal shift sequencer.
module tb_universal_shift_seq;
  localparam int W  = 8;
  localparam int CW = 4;

  logic clk;
  logic rst;

  universal_shift_seq_if #(.WIDTH(W), .CW(CW)) bus ();

  universal_shift_seq #(.WIDTH(W), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         rst;
    logic         start;
    logic [2:0]   mode;
    logic [CW-1:0] cnt;
    logic [W-1:0] din;
    logic         sin;
    logic         en;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic [2:0] m, logic [CW-1:0] c,
                              logic [W-1:0] d, logic si, logic e,
                              logic [W-1:0] eq, logic eb, logic ed);
    vec_t v;
    v.rst = r; v.start = s; v.mode = m; v.cnt = c; v.din = d;
    v.sin = si; v.en = e; v.q = eq; v.busy = eb; v.done = ed;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic r, logic s, logic [2:0] m, logic [CW-1:0] c,
                       logic [W-1:0] d, logic si, logic e);
    rst = r; bus.start = s; bus.mode = m; bus.cnt = c;
    bus.din = d; bus.sin = si; bus.en = e;
  endtask

  // Reference model: state kept as plain integers and flags.
  int unsigned m_q;
  int unsigned m_rem;
  int          m_mode;
  bit          m_busy;
  bit          m_done;

  function automatic int unsigned ref_step(int md, int unsigned x, int unsigned s);
    int unsigned mask = (1 << W) - 1;
    int unsigned msb  = 1 << (W - 1);
    case (md)
      1: return (x >> 1) | (s * msb);
      2: return ((x * 2) + s) & mask;
      4: return (x >> 1) | ((x % 2) * msb);
      5: return ((x * 2) & mask) | (x / msb);
      6: return (x >> 1) | (x & msb);
      default: return x;
    endcase
  endfunction

  task automatic model_tick();
    int md;
    md = int'(bus.mode);
    if (!rst) begin
      m_q = 0; m_rem = 0; m_busy = 0; m_done = 0; m_mode = 0;
    end else if (!m_busy) begin
      m_done = 0;
      if (bus.start) begin
        if (md == 3) begin
          m_q = int'(bus.din); m_done = 1;
        end else if ((md == 1 || md == 2 || md == 4 || md == 5 || md == 6) && bus.cnt != 0) begin
          m_busy = 1; m_rem = int'(bus.cnt); m_mode = md;
        end else begin
          m_done = 1;
        end
      end
    end else begin
      m_done = 0;
      if (bus.en) begin
        m_q = ref_step(m_mode, m_q, int'(bus.sin));
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_busy = 0; m_done = 1;
        end
      end
    end
  endtask

  initial begin
    logic [W-1:0] rol_seq [8];
    rol_seq = '{8'h4B, 8'h96, 8'h2D, 8'h5A, 8'hB4, 8'h69, 8'hD2, 8'hA5};

    // reset, load, ROL 3 with injected start
    vecs.push_back(mk(0,0,3'd0,0,8'h00,0,0, 8'h00,0,0));
    vecs.push_back(mk(1,1,3'd3,0,8'hA5,0,0, 8'hA5,0,1));
    vecs.push_back(mk(1,0,3'd0,0,8'h00,0,0, 8'hA5,0,0));
    vecs.push_back(mk(1,1,3'd5,3,8'h00,0,1, 8'hA5,1,0));
    vecs.push_back(mk(1,0,3'd0,0,8'h00,0,1, 8'h4B,1,0));
    vecs.push_back(mk(1,1,3'd3,0,8'h00,0,1, 8'h96,1,0));
    vecs.push_back(mk(1,0,3'd0,0,8'h00,0,1, 8'h2D,0,1));
    // ASR 2 from 96
    vecs.push_back(mk(1,1,3'd3,0,8'h96,0,0, 8'h96,0,1));
    vecs.push_back(mk(1,1,3'd6,2,8'h00,0,1, 8'h96,1,0));
    vecs.push_back(mk(1,0,3'd0,0,8'h00,0,1, 8'hCB,1,0));
    vecs.push_back(mk(1,0,3'd0,0,8'h00,0,1, 8'hE5,0,1));
    // SRL 4 with sin=1 from 00
    vecs.push_back(mk(1,1,3'd3,0,8'h00,0,0, 8'h00,0,1));
    vecs.push_back(mk(1,1,3'd1,4,8'h00,1,1, 8'h00,1,0));
    vecs.push_back(mk(1,0,3'd0,0,8'h00,1,1, 8'h80,1,0));
    vecs.push_back(mk(1,0,3'd0,0,8'h00,1,1, 8'hC0,1,0));
    vecs.push_back(mk(1,0,3'd0,0,8'h00,1,1, 8'hE0,1,0));
    vecs.push_back(mk(1,0,3'd0,0,8'h00,1,1, 8'hF0,0,1));
    // SLL 4 with a two-cycle pause after the second step
    vecs.push_back(mk(1,1,3'd2,4,8'h00,0,1, 8'hF0,1,0));
    vecs.push_back(mk(1,0,3'd0,0,8'h00,0,1, 8'hE0,1,0));
    vecs.push_back(mk(1,0,3'd0,0,8'h00,1,1, 8'hC1,1,0));
    vecs.push_back(mk(1,1,3'd3,0,8'hFF,1,0, 8'hC1,1,0));
    vecs.push_back(mk(1,0,3'd0,0,8'h00,0,0, 8'hC1,1,0));
    vecs.push_back(mk(1,0,3'd0,0,8'h00,1,1, 8'h83,1,0));
    vecs.push_back(mk(1,0,3'd0,0,8'h00,0,1, 8'h06,0,1));
    vecs.push_back(mk(1,0,3'd0,0,8'h00,0,1, 8'h06,0,0));
    // reserved mode and zero count
    vecs.push_back(mk(1,1,3'd7,3,8'h00,0,1, 8'h06,0,1));
    vecs.push_back(mk(1,1,3'd5,0,8'h00,0,1, 8'h06,0,1));
    vecs.push_back(mk(1,0,3'd0,0,8'h00,0,1, 8'h06,0,0));
    // ROL by WIDTH returns the original value
    vecs.push_back(mk(1,1,3'd3,0,8'hA5,0,0, 8'hA5,0,1));
    vecs.push_back(mk(1,1,3'd5,8,8'h00,0,1, 8'hA5,1,0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1,0,3'd0,0,8'h00,0,1, rol_seq[i], (i != 7), (i == 7)));
    // abort a cnt=5 SLL after two steps
    vecs.push_back(mk(1,1,3'd2,5,8'h00,0,1, 8'hA5,1,0));
    vecs.push_back(mk(1,0,3'd0,0,8'h00,0,1, 8'h4A,1,0));
    vecs.push_back(mk(1,0,3'd0,0,8'h00,0,1, 8'h94,1,0));
    vecs.push_back(mk(0,0,3'd0,0,8'h00,0,1, 8'h00,0,0));
    vecs.push_back(mk(1,0,3'd0,0,8'h00,0,1, 8'h00,0,0));
    vecs.push_back(mk(1,0,3'd0,0,8'h00,0,1, 8'h00,0,0));

    drive(0,0,3'd0,0,8'h00,0,0);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].mode, vecs[i].cnt,
            vecs[i].din, vecs[i].sin, vecs[i].en);
      @(posedge clk);
      #1;
      $display("vec %0d: q=%02h busy=%0b done=%0b", i, bus.q, bus.busy, bus.done);
      chk($sformatf("vec%0d q", i), 32'(bus.q), 32'(vecs[i].q));
      chk($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d done", i), 32'(bus.done), 32'(vecs[i].done));
      chk($sformatf("vec%0d sout_r", i), 32'(bus.sout_r), 32'(vecs[i].q[0]));
      chk($sformatf("vec%0d sout_l", i), 32'(bus.sout_l), 32'(vecs[i].q[W-1]));
    end

    // randomized run against the reference model
    drive(0,0,3'd0,0,8'h00,0,0);
    model_tick();
    @(posedge clk);
    #1;
    chk("rand reset q", 32'(bus.q), m_q);
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) == 0),
            3'($urandom_range(0, 7)), CW'($urandom_range(0, 15)),
            W'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0));
      model_tick();
      @(posedge clk);
      #1;
      if (m_done)
        $display("rand cycle %0d: command complete q=%02h", c, bus.q);
      chk("rand q", 32'(bus.q), m_q);
      chk("rand busy", 32'(bus.busy), 32'(m_busy));
      chk("rand done", 32'(bus.done), 32'(m_done));
      chk("rand sout_r", 32'(bus.sout_r), m_q % 2);
      chk("rand sout_l", 32'(bus.sout_l), m_q >> (W - 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
